// File: rtl/program_ram_if.sv
// program_ram_if -- bus bundle between the CPU/loader side and program_ram.
//
// Fetch side : fetch_en, address -> instruction (registered, 1-cycle latency)
// Load side  : load_start, load_valid/load_ready byte stream on load_data,
//              load_end for early termination
// Status     : cpu_stall, prog_valid, load_err, word_count
//
// master : the CPU/loader, which drives fetch and load requests
// slave  : the program RAM
interface program_ram_if #(
  parameter int ADDR_W = 4,
  parameter int INST_W = 16
);
  logic              fetch_en;
  logic [ADDR_W-1:0] address;
  logic [INST_W-1:0] instruction;
  logic              load_start;
  logic              load_valid;
  logic [7:0]        load_data;
  logic              load_ready;
  logic              load_end;
  logic              cpu_stall;
  logic              prog_valid;
  logic              load_err;
  logic [ADDR_W:0]   word_count;

  modport master (
    output fetch_en, address, load_start, load_valid, load_data, load_end,
    input  instruction, load_ready, cpu_stall, prog_valid, load_err, word_count
  );

  modport slave (
    input  fetch_en, address, load_start, load_valid, load_data, load_end,
    output instruction, load_ready, cpu_stall, prog_valid, load_err, word_count
  );
endinterface

// File: rtl/program_ram.sv
// program_ram -- instruction memory with a byte-serial program loader.
//
// A load is started with a load_start pulse. Bytes arrive MSB-first on the
// load_valid/load_ready stream and are packed into INST_W-bit words written
// sequentially from address 0. The load finishes when the memory fills or on
// load_end; a trailing partial word is dropped and flagged by load_err.
// While loading, cpu_stall is high and fetches return 0 (nop). In RUN with a
// valid program, fetches return mem[address] one cycle later.
//
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - program_ram_if slave modport (fetch, load stream, status)
module program_ram #(
  parameter int ADDR_W = 4,
  parameter int INST_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  program_ram_if.slave bus
);

  localparam int NBYTES = INST_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [INST_W-1:0] mem [DEPTH];

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W-1:0] wptr_reg, wptr_next;
  logic [BCNT_W-1:0] bcnt_reg, bcnt_next;
  logic [INST_W-1:0] asm_reg, asm_next;
  logic [INST_W-1:0] asm_shift;
  logic [ADDR_W:0]   wcnt_reg, wcnt_next;
  logic              pv_reg, pv_next;
  logic              err_reg, err_next;
  logic [INST_W-1:0] instr_reg;
  logic              mem_we;
  logic              mem_full;
  logic              unused_top;

  // Byte assembler: the new byte enters lane 0 and every older byte moves up
  // one lane, so the first byte of a word ends up in the MSBs.
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
      if (gi == 0) begin : g_first
        assign asm_shift[7:0] = bus.load_data;
      end else begin : g_rest
        assign asm_shift[8*gi +: 8] = asm_reg[8*(gi-1) +: 8];
      end
    end
  endgenerate

  // The top byte of the assembler is shifted out and never read.
  assign unused_top = ^asm_reg[INST_W-1 -: 8];

  assign mem_full = (wptr_reg == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_next = state_reg;
    wptr_next  = wptr_reg;
    bcnt_next  = bcnt_reg;
    asm_next   = asm_reg;
    wcnt_next  = wcnt_reg;
    pv_next    = pv_reg;
    err_next   = err_reg;
    mem_we     = 1'b0;

    if (bus.load_start) begin
      // Also covers a restart while loading: any partial word is dropped.
      state_next = ST_LOAD;
      wptr_next  = '0;
      bcnt_next  = '0;
      wcnt_next  = '0;
      pv_next    = 1'b0;
      err_next   = 1'b0;
    end else if (state_reg == ST_LOAD) begin
      if (bus.load_valid) begin
        if (bcnt_reg == BCNT_W'(NBYTES - 1)) begin
          mem_we    = 1'b1;
          wptr_next = wptr_reg + ADDR_W'(1);
          wcnt_next = wcnt_reg + (ADDR_W+1)'(1);
          bcnt_next = '0;
        end else begin
          asm_next  = asm_shift;
          bcnt_next = bcnt_reg + BCNT_W'(1);
        end
      end

      // A full memory completes the load even if load_end arrives with it.
      if (mem_we && mem_full) begin
        state_next = ST_RUN;
        pv_next    = 1'b1;
        err_next   = 1'b0;
      end else if (bus.load_end) begin
        // End is judged after this cycle's byte has been taken.
        state_next = ST_RUN;
        if (bcnt_next == '0) begin
          pv_next  = 1'b1;
          err_next = 1'b0;
        end else begin
          pv_next   = (wcnt_next != '0);
          err_next  = 1'b1;
          bcnt_next = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      wptr_reg  <= '0;
      bcnt_reg  <= '0;
      asm_reg   <= '0;
      wcnt_reg  <= '0;
      pv_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      wptr_reg  <= wptr_next;
      bcnt_reg  <= bcnt_next;
      asm_reg   <= asm_next;
      wcnt_reg  <= wcnt_next;
      pv_reg    <= pv_next;
      err_reg   <= err_next;
    end
  end

  // Storage is deliberately not reset so a program survives reset and reload.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wptr_reg] <= asm_shift;
    end
  end

  // Registered fetch. A load_start in the same cycle already yields a nop, so
  // the CPU never sees an instruction from a program that is being replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg <= '0;
    end else if (bus.fetch_en) begin
      if (state_reg == ST_RUN && pv_reg && !bus.load_start) begin
        instr_reg <= mem[bus.address];
      end else begin
        instr_reg <= '0;
      end
    end
  end

  assign bus.instruction = instr_reg;
  assign bus.load_ready  = (state_reg == ST_LOAD);
  assign bus.cpu_stall   = (state_reg == ST_LOAD);
  assign bus.prog_valid  = pv_reg;
  assign bus.load_err    = err_reg;
  assign bus.word_count  = wcnt_reg;

endmodule

// File: tb/tb_program_ram.sv
// tb_program_ram -- directed + randomized bench for program_ram.
// A byte-list model computes the words, word_count and flags of each load;
// fetch results are compared against the model memory image.
module tb_program_ram;

  localparam int AW = 4, IW = 16, NB = 2, DEPTH = 16;
  localparam int AW2 = 3, IW2 = 24, NB2 = 3, DEPTH2 = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_ram_if #(.ADDR_W(AW), .INST_W(IW)) bus ();
  program_ram_if #(.ADDR_W(AW2), .INST_W(IW2)) bus2 ();

  program_ram #(.ADDR_W(AW), .INST_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  program_ram #(.ADDR_W(AW2), .INST_W(IW2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: memory image and load status (0 idle, 1 loading, 2 run)
  logic [IW-1:0] model_mem [DEPTH];
  int            model_state;
  int            model_wc;
  logic          model_pv;
  logic          model_err;
  logic [7:0]    tx_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Applies the load rules to the byte list in tx_q.
  function automatic void model_load(input int end_mode);
    int nw, rem;
    logic [IW-1:0] word;
    nw = tx_q.size() / NB;
    if (nw > DEPTH) nw = DEPTH;
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int k = 0; k < NB; k++) word = word * 256 + IW'(tx_q[w*NB + k]);
      model_mem[w] = word;
    end
    rem = tx_q.size() - nw * NB;
    model_wc = nw;
    if (nw == DEPTH) begin
      model_state = 2; model_pv = 1'b1; model_err = 1'b0;
    end else if (end_mode != 0) begin
      model_state = 2;
      if (rem == 0) begin model_pv = 1'b1; model_err = 1'b0; end
      else begin model_pv = (nw > 0); model_err = 1'b1; end
    end else begin
      model_state = 1; model_pv = 1'b0; model_err = 1'b0;
    end
  endfunction

  // end_mode: 0 none, 1 with the last byte, 2 on its own cycle afterwards
  task automatic drive_load(input int end_mode, input bit do_start);
    if (do_start) begin
      bus.load_start = 1'b1; tick(); bus.load_start = 1'b0;
    end
    for (int i = 0; i < tx_q.size(); i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      bus.load_valid = 1'b1;
      bus.load_data  = tx_q[i];
      bus.load_end   = (end_mode == 1) && (i == tx_q.size() - 1);
      tick();
      bus.load_valid = 1'b0;
      bus.load_end   = 1'b0;
    end
    if (end_mode == 2 || (end_mode == 1 && tx_q.size() == 0)) begin
      bus.load_end = 1'b1; tick(); bus.load_end = 1'b0;
    end
    $display("load bytes=%0d end_mode=%0d wc=%0d pv=%0b err=%0b",
             tx_q.size(), end_mode, bus.word_count, bus.prog_valid, bus.load_err);
  endtask

  task automatic check_status(input string tag);
    check({tag, ".wc"}, 32'(bus.word_count), model_wc);
    check({tag, ".pv"}, 32'(bus.prog_valid), 32'(model_pv));
    check({tag, ".err"}, 32'(bus.load_err), 32'(model_err));
    check({tag, ".ready"}, 32'(bus.load_ready), (model_state == 1) ? 1 : 0);
    check({tag, ".stall"}, 32'(bus.cpu_stall), (model_state == 1) ? 1 : 0);
  endtask

  task automatic fetch_one(input int a);
    logic [IW-1:0] exp;
    bus.fetch_en = 1'b1;
    bus.address  = AW'(a);
    tick();
    bus.fetch_en = 1'b0;
    exp = (model_state == 2 && model_pv) ? model_mem[a] : '0;
    $display("fetch addr=%0d instr=%04h", a, bus.instruction);
    check($sformatf("fetch[%0d]", a), 32'(bus.instruction), 32'(exp));
  endtask

  task automatic fetch_all();
    for (int a = 0; a < DEPTH; a++) fetch_one(a);
  endtask

  task automatic fill_random(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
  endtask

  function automatic logic [7:0] sweep_byte(input int i);
    return 8'((i * 37 + 11) % 256);
  endfunction

  initial begin
    logic [IW2-1:0] exp2;
    int n, em;

    bus.fetch_en = 0; bus.address = '0; bus.load_start = 0;
    bus.load_valid = 0; bus.load_data = '0; bus.load_end = 0;
    bus2.fetch_en = 0; bus2.address = '0; bus2.load_start = 0;
    bus2.load_valid = 0; bus2.load_data = '0; bus2.load_end = 0;
    model_state = 0; model_wc = 0; model_pv = 0; model_err = 0;
    for (int a = 0; a < DEPTH; a++) model_mem[a] = 'x;

    // Reset state
    tick(); tick();
    check("rst.instr", 32'(bus.instruction), 0);
    check_status("rst");
    rst_n = 1'b1;
    tick();
    check_status("idle");
    fetch_one(3);

    // Full load, no load_end
    fill_random(32);
    drive_load(0, 1'b1);
    model_load(0);
    check_status("full");
    // 33rd byte must not be taken
    bus.load_valid = 1'b1; bus.load_data = 8'hA5;
    check("full.ready33", 32'(bus.load_ready), 0);
    tick();
    bus.load_valid = 1'b0;
    check_status("full33");
    fetch_all();
    // fetch_en low holds the last instruction
    tick();
    check("hold", 32'(bus.instruction), 32'(model_mem[DEPTH-1]));

    // Five-word reference program, load_end on its own cycle
    tx_q = '{8'hB2, 8'h01, 8'hB4, 8'h05, 8'h34, 8'h41, 8'hF4, 8'h00, 8'h82, 8'h00};
    drive_load(2, 1'b1);
    model_load(2);
    check_status("five");
    fetch_one(2);
    check("five.addr2", 32'(bus.instruction), 32'h3441);
    fetch_all();

    // Partial end: 3 bytes with load_end on the third
    fill_random(3);
    drive_load(1, 1'b1);
    model_load(1);
    check_status("partial");
    fetch_all();

    // Reload from RUN while fetching
    bus.fetch_en = 1'b1; bus.address = '0; bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0; bus.fetch_en = 1'b0;
    check("reload.instr", 32'(bus.instruction), 0);
    check("reload.stall", 32'(bus.cpu_stall), 1);
    fill_random(2);
    drive_load(1, 1'b0);
    model_load(1);
    check_status("reload");
    fetch_all();

    // Reset in the middle of a load
    fill_random(4);
    drive_load(0, 1'b1);
    model_load(0);
    rst_n = 1'b0;
    #1;
    model_state = 0; model_wc = 0; model_pv = 0; model_err = 0;
    check("midrst.instr", 32'(bus.instruction), 0);
    check_status("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    fetch_one(0);
    fetch_one(5);

    // Restart while loading: partial word of the first attempt is dropped
    fill_random(3);
    drive_load(0, 1'b1);
    model_load(0);
    fill_random(4);
    drive_load(1, 1'b1);
    model_load(1);
    check_status("restart");
    fetch_all();

    // Empty load, then a single-byte load
    tx_q.delete();
    drive_load(2, 1'b1);
    model_load(2);
    check_status("empty");
    fetch_one(4);
    fill_random(1);
    drive_load(1, 1'b1);
    model_load(1);
    check_status("onebyte");
    fetch_one(0);

    // Randomized loads
    for (int r = 0; r < 6; r++) begin
      n  = $urandom_range(0, 40);
      if (n > 2 * DEPTH) n = 2 * DEPTH;
      em = $urandom_range(1, 2);
      fill_random(n);
      drive_load(em, 1'b1);
      model_load(em);
      check_status($sformatf("rand%0d", r));
      for (int f = 0; f < 4; f++) fetch_one($urandom_range(0, DEPTH - 1));
    end

    // Second configuration: 3 bytes per word, 8 words
    bus2.load_start = 1'b1; tick(); bus2.load_start = 1'b0;
    for (int i = 0; i < NB2 * DEPTH2; i++) begin
      bus2.load_valid = 1'b1;
      bus2.load_data  = sweep_byte(i);
      tick();
      if (i == NB2 * DEPTH2 - 2) begin
        check("sweep.wc23", 32'(bus2.word_count), DEPTH2 - 1);
        check("sweep.ready23", 32'(bus2.load_ready), 1);
      end
    end
    bus2.load_valid = 1'b0;
    $display("sweep load bytes=%0d wc=%0d", NB2 * DEPTH2, bus2.word_count);
    check("sweep.wc", 32'(bus2.word_count), DEPTH2);
    check("sweep.ready", 32'(bus2.load_ready), 0);
    check("sweep.pv", 32'(bus2.prog_valid), 1);
    for (int a = 0; a < DEPTH2; a += 7) begin
      bus2.fetch_en = 1'b1; bus2.address = AW2'(a);
      tick();
      bus2.fetch_en = 1'b0;
      exp2 = {sweep_byte(3*a), sweep_byte(3*a + 1), sweep_byte(3*a + 2)};
      $display("sweep fetch addr=%0d instr=%06h", a, bus2.instruction);
      check($sformatf("sweep.fetch[%0d]", a), 32'(bus2.instruction), 32'(exp2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_ram.md
PROGRAM_RAM -- requirements
Module: program_ram

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set address width; depth = 2^ADDR_W words.
REQ-002 Parameter INST_W, default 16, SHALL set instruction width; legal values are multiples of 8 from 8 to 32.
REQ-003 Derived constant NBYTES = INST_W/8 SHALL be the number of load bytes per word.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 fetch_en  in  1  fetch strobe from the CPU.
REQ-007 address  in  ADDR_W  fetch address (the CPU PC).
REQ-008 instruction  out  INST_W  registered fetch data.
REQ-009 load_start  in  1  single-cycle pulse that begins a program load.
REQ-010 load_valid  in  1  load_data holds a byte.
REQ-011 load_data  in  8  program byte, MSB-first within each word.
REQ-012 load_ready  out  1  byte acceptance; a byte transfers when load_valid and load_ready are both high.
REQ-013 load_end  in  1  terminates a load early.
REQ-014 cpu_stall  out  1  high while loading; the CPU shall not advance.
REQ-015 prog_valid  out  1  a complete program is resident.
REQ-016 load_err  out  1  sticky; the last load ended mid-word.
REQ-017 word_count  out  ADDR_W+1  number of words written by the last load.

Function
REQ-018 The FSM SHALL have three states: IDLE, LOAD and RUN.
- Exit reset -> IDLE.
- load_start in any state -> LOAD.
- LOAD -> RUN on completion (REQ-022 or REQ-023).
REQ-019 On entering LOAD, the block SHALL clear the write pointer, byte counter, word_count, prog_valid and load_err.
- A load_start pulse while already in LOAD restarts the load and discards any partial word.
REQ-020 load_ready SHALL equal 1 exactly when the state is LOAD; cpu_stall SHALL equal load_ready.
REQ-021 Byte assembly:
- Each accepted byte shifts into the word assembler, first byte into the MSBs.
- On the NBYTES-th byte, the assembled word is written to mem[wptr]; wptr and word_count increment and the byte counter clears.
- This all happens in the same cycle as the final byte.
REQ-022 When a word is written at wptr = 2^ADDR_W-1 (memory full):
- The load completes in that cycle; next state is RUN.
- word_count = 2^ADDR_W; prog_valid = 1.
- Further bytes are not accepted.
REQ-023 load_end in LOAD completes the load in that cycle.
- If load_valid is asserted in the same cycle, that byte is accepted first, then end is evaluated.
- If the byte counter (after that byte) is 0: prog_valid = 1, load_err = 0.
- Otherwise: the partial word is discarded, load_err = 1, prog_valid = 1 if word_count > 0, else 0.
REQ-024 Words not written by a load SHALL retain their prior contents; memory SHALL NOT be cleared by reset or by load_start.
REQ-025 Fetch: on a rising edge with fetch_en = 1, instruction <= mem[address] if the state is RUN and prog_valid = 1; otherwise instruction <= 0 (nop).
- Latency is exactly 1 cycle.
- With fetch_en = 0, instruction holds its value.
REQ-026 Address wrap: address is used modulo depth, with no range check.
REQ-027 A word being written in cycle N SHALL NOT be fetched in cycle N, because fetch is blocked in LOAD; no read-during-write bypass is required.
REQ-028 A load_start pulse in RUN SHALL force instruction to 0 on the next fetch, and cpu_stall SHALL rise in the following cycle.

Reset
REQ-029 Reset SHALL be asynchronous on rst_n low, with immediate effect:
- state = IDLE; instruction = 0.
- load_ready = cpu_stall = prog_valid = load_err = 0; word_count = 0.
- wptr and byte counter = 0.
REQ-030 Reset during LOAD SHALL abandon the load; words already written remain in memory but prog_valid = 0.
REQ-031 Deassertion of rst_n SHALL take effect on the next rising clk edge; no fetch or load occurs in the release cycle's preceding half.

Verification
REQ-032 Defaults, load 5 words: 10 bytes B2,01,B4,05,34,41,F4,00,82,00 then load_end -> word_count = 5, prog_valid = 1, load_err = 0; fetching address 2 returns 16'h3441 one cycle later.
REQ-033 Full load: 32 bytes without load_end -> RUN after byte 32, word_count = 16, load_ready = 0; a 33rd byte is not accepted; a fetch of address 15 returns the last word.
REQ-034 Partial end: 3 bytes then load_end -> word_count = 1, load_err = 1, prog_valid = 1; mem[1] is unchanged from its prior value.
REQ-035 Reset mid-load: rst_n low after 4 bytes -> all outputs zero immediately; a fetch after release returns 0 until a new load completes.
REQ-036 Reload in RUN: load_start with fetch_en high -> the next instruction is 0 and cpu_stall = 1; the new 1-word load with load_end gives word_count = 1, and mem[1..15] keeps the prior program.
REQ-037 Parameter sweep: ADDR_W = 3, INST_W = 24 -> 3 bytes per word; a full load completes after 24 bytes with word_count = 8.
